// File: rtl/demux4.sv
// demux4: 1-to-4 stream demultiplexer with a 1-deep valid/ready holding
// register per output channel. A word on din is steered to the channel named
// by select. Each channel stalls independently, so a full channel never
// blocks words addressed to the others.
//
// Optional feature: define DEMUX4_COUNT_EN to add per-channel accepted-transfer
// counters (ports cnt1..cnt4, CNT_WIDTH bits, wrapping). Without the macro the
// counter ports and logic are absent and data behaviour is unchanged.

// One output channel: a data register plus a valid bit.
module demux4_chan #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,       // input transfer addressed to this channel
    input  logic [WIDTH-1:0] load_data,
    input  logic             take,       // consumer takes the held word
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    // A load wins over a take so the channel can refill in the cycle it drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (take) begin
            valid <= 1'b0;
        end
    end

endmodule

module demux4 #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     din,
    input  logic [1:0]           select,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic [WIDTH-1:0]     dout1,
    output logic [WIDTH-1:0]     dout2,
    output logic [WIDTH-1:0]     dout3,
    output logic [WIDTH-1:0]     dout4,
    output logic                 dout_valid1,
    output logic                 dout_valid2,
    output logic                 dout_valid3,
    output logic                 dout_valid4,
    input  logic                 dout_ready1,
    input  logic                 dout_ready2,
    input  logic                 dout_ready3,
    input  logic                 dout_ready4
`ifdef DEMUX4_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0] cnt1,
    output logic [CNT_WIDTH-1:0] cnt2,
    output logic [CNT_WIDTH-1:0] cnt3,
    output logic [CNT_WIDTH-1:0] cnt4
`endif
);

    localparam int NUM_CH = 4;

    logic [NUM_CH-1:0]            ch_valid;
    logic [NUM_CH-1:0]            ch_ready;
    logic [NUM_CH-1:0]            ch_load;
    logic [NUM_CH-1:0][WIDTH-1:0] ch_data;
    logic                         in_xfer;

    assign ch_ready = {dout_ready4, dout_ready3, dout_ready2, dout_ready1};

    // Ready looks only at the addressed channel; a re-select while stalled
    // re-evaluates immediately since nothing is latched for the old select.
    assign din_ready = ~ch_valid[select] | ch_ready[select];
    assign in_xfer   = din_valid & din_ready;

    // One-hot load strobe toward the selected channel.
    always_comb begin
        ch_load         = '0;
        ch_load[select] = in_xfer;
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        demux4_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .load      (ch_load[gi]),
            .load_data (din),
            .take      (ch_valid[gi] & ch_ready[gi]),
            .data      (ch_data[gi]),
            .valid     (ch_valid[gi])
        );
    end

    assign dout1       = ch_data[0];
    assign dout2       = ch_data[1];
    assign dout3       = ch_data[2];
    assign dout4       = ch_data[3];
    assign dout_valid1 = ch_valid[0];
    assign dout_valid2 = ch_valid[1];
    assign dout_valid3 = ch_valid[2];
    assign dout_valid4 = ch_valid[3];

`ifdef DEMUX4_COUNT_EN
    logic [NUM_CH-1:0][CNT_WIDTH-1:0] cnt_q;

    // Count accepted input words per destination; wraps silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (in_xfer) begin
            cnt_q[select] <= cnt_q[select] + 1'b1;
        end
    end

    assign cnt1 = cnt_q[0];
    assign cnt2 = cnt_q[1];
    assign cnt3 = cnt_q[2];
    assign cnt4 = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux4.sv
// Testbench for demux4: directed scenarios plus a randomised run, all checked
// against a per-channel queue model of what each channel should be holding.
module tb_demux4;

    localparam int W = 8;
`ifdef DEMUX4_COUNT_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 16;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [W-1:0]        din;
    logic [1:0]          sel;
    logic                din_valid;
    logic                din_ready;
    logic [3:0][W-1:0]   dout;
    logic [3:0]          dvalid;
    logic [3:0]          rdy;
`ifdef DEMUX4_COUNT_EN
    logic [3:0][CNT_W-1:0] cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Model: words each channel should currently hold (front = visible),
    // last word delivered per channel, and expected counters.
    logic [W-1:0] q[4][$];
    logic [W-1:0] last_out[4];
    int           m_cnt[4];

    always #5 clk = ~clk;

    demux4 #(.WIDTH(W), .CNT_WIDTH(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .select      (sel),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .dout1       (dout[0]),
        .dout2       (dout[1]),
        .dout3       (dout[2]),
        .dout4       (dout[3]),
        .dout_valid1 (dvalid[0]),
        .dout_valid2 (dvalid[1]),
        .dout_valid3 (dvalid[2]),
        .dout_valid4 (dvalid[3]),
        .dout_ready1 (rdy[0]),
        .dout_ready2 (rdy[1]),
        .dout_ready3 (rdy[2]),
        .dout_ready4 (rdy[3])
`ifdef DEMUX4_COUNT_EN
        ,
        .cnt1        (cnt[0]),
        .cnt2        (cnt[1]),
        .cnt3        (cnt[2]),
        .cnt4        (cnt[3])
`endif
    );

    // One clock: compare DUT against the model mid-cycle, then advance the model.
    task automatic cycle();
        logic       exp_rdy;
        logic       in_x;
        logic [3:0] out_x;
        logic [1:0] s;
        logic [W-1:0] d;
        logic       r;
        @(negedge clk);
        s = sel;
        d = din;
        r = rst;
        exp_rdy = (q[s].size() == 0) || rdy[s];
        checks++;
        if (din_ready !== exp_rdy) begin
            errors++;
            $display("FAIL din_ready sel=%0d got %b want %b", s, din_ready, exp_rdy);
        end
        for (int n = 0; n < 4; n++) begin
            logic         ev;
            logic [W-1:0] ed;
            ev = (q[n].size() != 0);
            ed = ev ? q[n][0] : last_out[n];
            checks++;
            if (dvalid[n] !== ev || dout[n] !== ed) begin
                errors++;
                $display("FAIL chan%0d valid/data got %b/%h want %b/%h", n + 1, dvalid[n], dout[n], ev, ed);
            end
`ifdef DEMUX4_COUNT_EN
            checks++;
            if (cnt[n] !== CNT_W'(m_cnt[n])) begin
                errors++;
                $display("FAIL cnt%0d got %0d want %0d", n + 1, cnt[n], m_cnt[n]);
            end
`endif
            out_x[n] = ev && rdy[n] && !r;
        end
        in_x = din_valid && exp_rdy && !r;
        @(posedge clk);
        #1;
        if (r) begin
            for (int n = 0; n < 4; n++) begin
                q[n].delete();
                last_out[n] = '0;
                m_cnt[n]    = 0;
            end
        end else begin
            for (int n = 0; n < 4; n++)
                if (out_x[n]) last_out[n] = q[n].pop_front();
            if (in_x) begin
                q[s].push_back(d);
                m_cnt[s] = (m_cnt[s] + 1) % (1 << CNT_W);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; din = '0; sel = '0; din_valid = 1'b0; rdy = '0;
        for (int n = 0; n < 4; n++) begin
            q[n].delete(); last_out[n] = '0; m_cnt[n] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (dvalid[n] !== 1'b0 || dout[n] !== '0) begin
                errors++;
                $display("FAIL reset chan%0d got %b/%h want 0/00", n + 1, dvalid[n], dout[n]);
            end
        end
        checks++;
        if (din_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset din_ready got %b want 1", din_ready);
        end
        cycle();
    endtask

    task automatic test_route();
        din = 8'hA5; sel = 2'd2; din_valid = 1'b1; rdy = '0;
        cycle();
        din_valid = 1'b0;
        checks++;
        if (dout[2] !== 8'hA5 || dvalid !== 4'b0100) begin
            errors++;
            $display("FAIL route dout3/valids got %h/%b want a5/0100", dout[2], dvalid);
        end
    endtask

    task automatic test_stall_reselect();
        din = 8'h3C; sel = 2'd2; din_valid = 1'b1; rdy = '0;
        #1;
        checks++;
        if (din_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall din_ready got %b want 0", din_ready);
        end
        sel = 2'd0;
        #1;
        checks++;
        if (din_ready !== 1'b1) begin
            errors++;
            $display("FAIL reselect din_ready got %b want 1", din_ready);
        end
        cycle();
        din_valid = 1'b0;
        checks++;
        if (dout[0] !== 8'h3C || dout[2] !== 8'hA5 || dvalid !== 4'b0101) begin
            errors++;
            $display("FAIL reselect dout1/dout3/valids got %h/%h/%b want 3c/a5/0101", dout[0], dout[2], dvalid);
        end
    endtask

    task automatic test_back_to_back();
        rdy = 4'b0010; sel = 2'd1; din_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            din = W'(i);
            #1;
            checks++;
            if (din_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b din_ready word %0d got %b want 1", i, din_ready);
            end
            cycle();
            checks++;
            if (dout[1] !== W'(i) || dvalid[1] !== 1'b1) begin
                errors++;
                $display("FAIL b2b dout2 got %h/%b want %h/1", dout[1], dvalid[1], W'(i));
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic test_reset_midflight();
        rdy = 4'hF; din_valid = 1'b0;
        cycle();
        rdy = '0; sel = 2'd3; din = 8'h77; din_valid = 1'b1;
        cycle();
        checks++;
        if (dout[3] !== 8'h77 || dvalid[3] !== 1'b1) begin
            errors++;
            $display("FAIL preload dout4 got %h/%b want 77/1", dout[3], dvalid[3]);
        end
        rst = 1'b1; din = 8'h11; rdy = 4'hF;
        cycle();
        rst = 1'b0; din_valid = 1'b0;
        checks++;
        if (dvalid !== 4'b0000 || dout !== '0) begin
            errors++;
            $display("FAIL midreset valids/douts got %b/%h want 0/0", dvalid, dout);
        end
`ifdef DEMUX4_COUNT_EN
        checks++;
        if (cnt !== '0) begin
            errors++;
            $display("FAIL midreset cnt got %h want 0", cnt);
        end
`endif
    endtask

`ifdef DEMUX4_COUNT_EN
    task automatic test_count_wrap();
        rdy = 4'b0001; sel = 2'd0; din_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            din = W'($urandom);
            cycle();
        end
        din_valid = 1'b0;
        checks++;
        if (cnt[0] !== CNT_W'(1) || cnt[1] !== '0 || cnt[2] !== '0 || cnt[3] !== '0) begin
            errors++;
            $display("FAIL wrap cnt got %0d/%0d/%0d/%0d want 1/0/0/0", cnt[0], cnt[1], cnt[2], cnt[3]);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 10000; i++) begin
            din       = W'($urandom);
            sel       = 2'($urandom_range(0, 3));
            din_valid = 1'($urandom_range(0, 3) != 0);
            rdy       = 4'($urandom);
            cycle();
        end
        // Drain and confirm every channel empties out in order.
        din_valid = 1'b0; rdy = 4'hF;
        repeat (3) cycle();
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (dvalid[n] !== 1'b0 || q[n].size() != 0) begin
                errors++;
                $display("FAIL drain chan%0d valid %b pending %0d want 0/0", n + 1, dvalid[n], q[n].size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_route();
        test_stall_reselect();
        test_back_to_back();
        test_reset_midflight();
`ifdef DEMUX4_COUNT_EN
        test_count_wrap();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
